// File: rtl/hmc_token_pkg.sv
// Shared types and helpers for the HMC responder token-return logic.
// Used by hmc_rsp_token_return and, when HMC_TOKEN_STATS_EN is defined, hmc_token_stats_cnt.
package hmc_token_pkg;

    localparam int RTC_W = 5;
    localparam logic [RTC_W-1:0] RTC_MAX = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        REQ  = 2'd2
    } tret_state_t;

    // Clamp a token count to what a single RTC field can carry.
    function automatic logic [RTC_W-1:0] min_rtc(input logic [31:0] tokens);
        if (tokens > 32'(RTC_MAX)) begin
            return RTC_MAX;
        end
        return tokens[RTC_W-1:0];
    endfunction

endpackage

// File: rtl/hmc_token_stats_cnt.sv
// Wrapping 32-bit accumulator of returned tokens; only compiled when HMC_TOKEN_STATS_EN is defined.
// Cleared only by the asynchronous reset so totals survive link retraining.
`ifdef HMC_TOKEN_STATS_EN
module hmc_token_stats_cnt
    import hmc_token_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    input  logic [RTC_W-1:0] inc_val,
    output logic [31:0]      count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_en) begin
            count_d = count_q + 32'(inc_val);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/hmc_rsp_token_return.sv
// Responder-side HMC link token return: piggybacks freed input-buffer tokens on response tails, else requests a TRET.
// Defining HMC_TOKEN_STATS_EN adds stat_piggy_tokens / stat_tret_tokens running totals.
module hmc_rsp_token_return
    import hmc_token_pkg::*;
#(
    parameter int FPW                = 4,
    parameter int LOG_FPW            = 2,
    parameter int LOG_MAX_HMC_TOKENS = 10,
    parameter int TRET_THRESHOLD     = 8,
    parameter int TRET_IDLE_CYCLES   = 16
) (
    input  logic                          clk_hmc,
    input  logic                          res_n_hmc,
    input  logic                          link_up,
    input  logic [LOG_FPW:0]              flits_freed,
    input  logic                          rsp_tail_valid,
    output logic [RTC_W-1:0]              rsp_rtc,
    output logic                          tret_valid,
    input  logic                          tret_ready,
    output logic [RTC_W-1:0]              tret_rtc,
    output logic [LOG_MAX_HMC_TOKENS:0]   tokens_pending,
    output logic                          overflow_err
`ifdef HMC_TOKEN_STATS_EN
    ,
    output logic [31:0]                   stat_piggy_tokens,
    output logic [31:0]                   stat_tret_tokens
`endif
);

    localparam int PW = LOG_MAX_HMC_TOKENS + 1;
    localparam int CW = $clog2(TRET_IDLE_CYCLES + 1);
    localparam logic [PW:0]      MAX_TOKENS = (PW+1)'(2 ** LOG_MAX_HMC_TOKENS);
    localparam logic [PW-1:0]    THRESHOLD  = PW'(TRET_THRESHOLD);
    localparam logic [CW-1:0]    CNT_LAST   = CW'(TRET_IDLE_CYCLES - 1);
    localparam logic [LOG_FPW:0] FPW_MAX    = (LOG_FPW+1)'(FPW);

    tret_state_t      state_q, state_d;
    logic [CW-1:0]    idle_cnt_q, idle_cnt_d;
    logic [PW-1:0]    pending_q, pending_d;
    logic             tret_valid_q, tret_valid_d;
    logic [RTC_W-1:0] tret_rtc_q, tret_rtc_d;
    logic             overflow_q, overflow_d;

    logic [PW-1:0]    reserved;
    logic [PW-1:0]    avail;
    logic [RTC_W-1:0] avail_rtc;
    logic             avail_ge_th;
    logic             tret_acc;
    logic [RTC_W-1:0] piggy_amt;
    logic [RTC_W-1:0] tret_amt;
    logic [PW:0]      pending_sum;

    // Tokens promised to an outstanding TRET are fenced off so a tail cannot return them again.
    assign reserved    = (state_q == REQ) ? {{(PW-RTC_W){1'b0}}, tret_rtc_q} : '0;
    assign avail       = pending_q - reserved;
    assign avail_rtc   = min_rtc(32'(avail));
    assign avail_ge_th = (avail >= THRESHOLD);
    assign tret_acc    = tret_valid_q & tret_ready;
    assign piggy_amt   = rsp_tail_valid ? avail_rtc : '0;
    assign tret_amt    = tret_acc ? tret_rtc_q : '0;
    assign pending_sum = {1'b0, pending_q} + (PW+1)'(flits_freed)
                       - (PW+1)'(piggy_amt) - (PW+1)'(tret_amt);

    // State register
    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            state_q      <= IDLE;
            idle_cnt_q   <= '0;
            pending_q    <= '0;
            tret_valid_q <= 1'b0;
            tret_rtc_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            pending_q    <= pending_d;
            tret_valid_q <= tret_valid_d;
            tret_rtc_q   <= tret_rtc_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        if (!link_up) begin
            state_d    = IDLE;
            idle_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    idle_cnt_d = '0;
                    if (avail_ge_th) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (!avail_ge_th) begin
                        state_d    = IDLE;
                        idle_cnt_d = '0;
                    end else if (rsp_tail_valid) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == CNT_LAST) begin
                        state_d    = REQ;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
                REQ: begin
                    if (tret_acc) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    idle_cnt_d = '0;
                end
            endcase
        end
    end

    // Output and token-accounting logic
    always_comb begin
        pending_d    = pending_q;
        tret_valid_d = tret_valid_q;
        tret_rtc_d   = tret_rtc_q;
        overflow_d   = overflow_q;
        if (!link_up) begin
            pending_d    = '0;
            tret_valid_d = 1'b0;
            tret_rtc_d   = '0;
            overflow_d   = 1'b0;
        end else begin
            if (pending_sum > MAX_TOKENS) begin
                pending_d  = MAX_TOKENS[PW-1:0];
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_sum[PW-1:0];
            end
            if (state_q == WAIT && state_d == REQ) begin
                tret_valid_d = 1'b1;
                tret_rtc_d   = avail_rtc;
            end else if (tret_acc) begin
                tret_valid_d = 1'b0;
            end
        end
    end

    assign rsp_rtc        = avail_rtc;
    assign tret_valid     = tret_valid_q;
    assign tret_rtc       = tret_rtc_q;
    assign tokens_pending = pending_q;
    assign overflow_err   = overflow_q;

`ifdef HMC_TOKEN_STATS_EN
    hmc_token_stats_cnt u_stat_piggy (
        .clk     (clk_hmc),
        .rst_n   (res_n_hmc),
        .inc_en  (link_up & rsp_tail_valid),
        .inc_val (piggy_amt),
        .count   (stat_piggy_tokens)
    );

    hmc_token_stats_cnt u_stat_tret (
        .clk     (clk_hmc),
        .rst_n   (res_n_hmc),
        .inc_en  (link_up & tret_acc),
        .inc_val (tret_amt),
        .count   (stat_tret_tokens)
    );
`endif

    a_flits_freed_legal : assert property (
        @(posedge clk_hmc) disable iff (!res_n_hmc) flits_freed <= FPW_MAX
    );

endmodule

// File: tb/tb_hmc_rsp_token_return.sv
// Scoreboard bench for hmc_rsp_token_return: expected RTCs are queued by stimulus, popped by a monitor on tails/TRET handshakes.
// Stat-counter checks are included when HMC_TOKEN_STATS_EN is defined.
module tb_hmc_rsp_token_return;

    logic        clk_hmc = 1'b0;
    logic        res_n_hmc;
    logic        link_up;
    logic [2:0]  flits_freed;
    logic        rsp_tail_valid;
    logic [4:0]  rsp_rtc;
    logic        tret_valid;
    logic        tret_ready;
    logic [4:0]  tret_rtc;
    logic [10:0] tokens_pending;
    logic        overflow_err;
`ifdef HMC_TOKEN_STATS_EN
    logic [31:0] stat_piggy_tokens;
    logic [31:0] stat_tret_tokens;
`endif

    hmc_rsp_token_return dut (
        .clk_hmc        (clk_hmc),
        .res_n_hmc      (res_n_hmc),
        .link_up        (link_up),
        .flits_freed    (flits_freed),
        .rsp_tail_valid (rsp_tail_valid),
        .rsp_rtc        (rsp_rtc),
        .tret_valid     (tret_valid),
        .tret_ready     (tret_ready),
        .tret_rtc       (tret_rtc),
        .tokens_pending (tokens_pending),
        .overflow_err   (overflow_err)
`ifdef HMC_TOKEN_STATS_EN
        ,
        .stat_piggy_tokens (stat_piggy_tokens),
        .stat_tret_tokens  (stat_tret_tokens)
`endif
    );

    always #5 clk_hmc = ~clk_hmc;

    int n_tests = 0;
    int n_fail  = 0;
    int rsp_q[$];
    int tret_q[$];
    int exp_piggy_sum = 0;
    int exp_tret_sum  = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok   %s: %0d", name, act);
        end
    endfunction

    function automatic void push_rsp(input int v);
        rsp_q.push_back(v);
        exp_piggy_sum += v;
    endfunction

    function automatic void push_tret(input int v);
        tret_q.push_back(v);
        exp_tret_sum += v;
    endfunction

    // Monitor: samples mid-cycle, compares every returned RTC against the queued expectation.
    always @(negedge clk_hmc) begin
        if (res_n_hmc && link_up && rsp_tail_valid) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected_tail", 1, 0);
            else chk("rsp_rtc", int'(rsp_rtc), rsp_q.pop_front());
        end
        if (res_n_hmc && link_up && tret_valid && tret_ready) begin
            if (tret_q.size() == 0) chk("tret_unexpected_accept", 1, 0);
            else chk("tret_rtc", int'(tret_rtc), tret_q.pop_front());
        end
    end

    // Apply inputs just after a rising edge, hold them for one full cycle.
    task automatic cyc(input int ff, input bit tail, input bit rdy);
        flits_freed    = 3'(ff);
        rsp_tail_valid = tail;
        tret_ready     = rdy;
        @(posedge clk_hmc);
        #1;
    endtask

    task automatic wait_tret(input string name, output int n);
        n = 0;
        while (!tret_valid && n < 40) begin
            cyc(0, 0, 0);
            n++;
        end
        chk(name, int'(tret_valid), 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        res_n_hmc      = 1'b0;
        link_up        = 1'b0;
        flits_freed    = '0;
        rsp_tail_valid = 1'b0;
        tret_ready     = 1'b0;
        repeat (3) @(posedge clk_hmc);
        #1;
        chk("reset_pending", int'(tokens_pending), 0);
        chk("reset_tret_valid", int'(tret_valid), 0);
        chk("reset_overflow", int'(overflow_err), 0);
        chk("reset_rsp_rtc", int'(rsp_rtc), 0);
        res_n_hmc = 1'b1;
        link_up   = 1'b1;

        // 1: accumulate 8 tokens, TRET after IDLE->WAIT edge plus 16 tail-free WAIT cycles
        cyc(4, 0, 0);
        cyc(4, 0, 0);
        chk("t1_pending", int'(tokens_pending), 8);
        wait_tret("t1_tret_valid", n);
        chk("t1_tret_latency", n, 17);
        chk("t1_tret_rtc", int'(tret_rtc), 8);
        push_tret(8);
        cyc(0, 0, 1);
        chk("t1_pending_after", int'(tokens_pending), 0);
        chk("t1_tret_dropped", int'(tret_valid), 0);
        cyc(0, 0, 0);

        // 2: pending=40, tail concurrent with 4 freed -> rtc 31, next pending 13
        repeat (10) cyc(4, 0, 0);
        chk("t2_pending40", int'(tokens_pending), 40);
        chk("t2_rsp_rtc_clamp", int'(rsp_rtc), 31);
        push_rsp(31);
        cyc(4, 1, 0);
        chk("t2_pending13", int'(tokens_pending), 13);
        push_rsp(13);
        cyc(0, 1, 0);
        chk("t2_drained", int'(tokens_pending), 0);
        cyc(0, 0, 0);

        // 3: REQ holding 10, pending 12, tail returns only the unreserved 2
        cyc(4, 0, 0);
        cyc(4, 0, 0);
        cyc(2, 0, 0);
        wait_tret("t3_tret_valid", n);
        chk("t3_tret_rtc", int'(tret_rtc), 10);
        cyc(2, 0, 0);
        chk("t3_pending12", int'(tokens_pending), 12);
        chk("t3_rsp_rtc_req", int'(rsp_rtc), 2);
        push_rsp(2);
        cyc(0, 1, 0);
        chk("t3_pending10", int'(tokens_pending), 10);
        chk("t3_tret_rtc_held", int'(tret_rtc), 10);
        repeat (4) cyc(0, 0, 0);
        chk("t3_tret_still_valid", int'(tret_valid), 1);
        push_tret(10);
        cyc(0, 0, 1);
        chk("t3_pending0", int'(tokens_pending), 0);
        chk("t3_tret_dropped", int'(tret_valid), 0);
        cyc(0, 0, 0);

        // 4: a tail every 10 cycles keeps the idle count from ever expiring
        for (int r = 0; r < 6; r++) begin
            seen = 1'b0;
            for (int k = 0; k < 9; k++) begin
                cyc(1, 0, 0);
                seen |= tret_valid;
            end
            push_rsp(9);
            cyc(0, 1, 0);
            seen |= tret_valid;
            chk($sformatf("t4_no_tret_round%0d", r), int'(seen), 0);
        end
        cyc(0, 0, 0);
        chk("t4_pending0", int'(tokens_pending), 0);

        // 5: saturate at 1024 and set sticky overflow; link down clears
        repeat (256) cyc(4, 0, 0);
        chk("t5_pending1024", int'(tokens_pending), 1024);
        chk("t5_no_overflow_yet", int'(overflow_err), 0);
        cyc(2, 0, 0);
        chk("t5_pending_sat", int'(tokens_pending), 1024);
        chk("t5_overflow", int'(overflow_err), 1);
        cyc(0, 0, 0);
        chk("t5_overflow_sticky", int'(overflow_err), 1);
        link_up = 1'b0;
        cyc(0, 0, 0);
        chk("t5_linkdown_pending", int'(tokens_pending), 0);
        chk("t5_linkdown_overflow", int'(overflow_err), 0);
        chk("t5_linkdown_tret", int'(tret_valid), 0);
        link_up = 1'b1;
        cyc(0, 0, 0);

        // 6: link drop mid-REQ (ready high is ignored) -> TRET gone, FSM back to IDLE
        cyc(4, 0, 0);
        cyc(4, 0, 0);
        wait_tret("t6_tret_valid", n);
        link_up = 1'b0;
        cyc(4, 1, 1);
        chk("t6_linkdown_tret", int'(tret_valid), 0);
        chk("t6_linkdown_pending", int'(tokens_pending), 0);
        link_up = 1'b1;
        repeat (3) cyc(0, 0, 0);
        chk("t6_idle_no_tret", int'(tret_valid), 0);
        chk("t6_idle_pending", int'(tokens_pending), 0);
`ifdef HMC_TOKEN_STATS_EN
        chk("stat_piggy_total", int'(stat_piggy_tokens), exp_piggy_sum);
        chk("stat_tret_total", int'(stat_tret_tokens), exp_tret_sum);
`endif

        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("tret_queue_drained", tret_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
